// File: rtl/l1d_store_drain_buf.sv
// l1d_store_drain_buf
//
// This buffer sits in front of the L1D data array write port, which has
// 128 bits and 16 byte enables. It holds committed stores in an in-order
// circular queue. A store that targets the same index as the youngest entry
// is merged into that entry. The buffer drains one entry per cycle into the
// array whenever the write port is free. It also returns registered
// store-to-load forwarding data, aligned to the array's one-cycle read
// latency.
//
// Ports
//   clk_i, rst_ni          clock; asynchronous active-low reset
//   st_valid_i/st_ready_o  store handshake
//   st_addr_i, st_data_i   store array index and byte-lane-aligned data
//   st_byte_en_i           store byte lanes
//   arr_busy_i             array write port taken this cycle; no drain
//   wr_en_o, wr_addr_o     array write strobe and index (head entry)
//   wr_data_o, wr_byte_en_o  array write data and byte enables
//   ld_valid_i, ld_addr_i  load probing the array this cycle
//   ld_fwd_byte_en_o       registered: lanes supplied by the buffer
//   ld_fwd_data_o          registered: forwarded data, unsupplied lanes zero
//   empty_o                no valid entries

module l1d_store_drain_buf #(
  parameter int unsigned LgDepth   = 1,
  parameter int unsigned LgEntries = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               st_valid_i,
  output logic               st_ready_o,
  input  logic [LgDepth-1:0] st_addr_i,
  input  logic [127:0]       st_data_i,
  input  logic [15:0]        st_byte_en_i,
  input  logic               arr_busy_i,
  output logic               wr_en_o,
  output logic [LgDepth-1:0] wr_addr_o,
  output logic [127:0]       wr_data_o,
  output logic [15:0]        wr_byte_en_o,
  input  logic               ld_valid_i,
  input  logic [LgDepth-1:0] ld_addr_i,
  output logic [15:0]        ld_fwd_byte_en_o,
  output logic [127:0]       ld_fwd_data_o,
  output logic               empty_o
);

  localparam int unsigned Entries = 1 << LgEntries;

  typedef logic [LgEntries-1:0] ptr_t;
  typedef logic [LgEntries:0]   cnt_t;

  // Entry storage. It is not reset because head, tail and count decide
  // which entries are valid.
  logic [LgDepth-1:0] addr_q [Entries];
  logic [127:0]       data_q [Entries];
  logic [15:0]        be_q   [Entries];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [15:0]  fwd_be_q, fwd_be_d;
  logic [127:0] fwd_data_q, fwd_data_d;

  ptr_t         young;
  ptr_t         fwd_idx;
  logic         drain, merge_ok, accept, do_alloc, do_merge;
  logic [127:0] merge_data;

  always_comb begin
    young    = tail_q - ptr_t'(1);
    drain    = (count_q != '0) && !arr_busy_i;
    // The youngest entry is not mergeable while it is the only entry and
    // is leaving the buffer this cycle.
    merge_ok = (count_q != '0) && (addr_q[young] == st_addr_i) &&
               !((count_q == cnt_t'(1)) && drain);
    // When the buffer is full, a drain in the same cycle does not make room.
    st_ready_o = merge_ok || (count_q != cnt_t'(Entries));
    accept   = st_valid_i && st_ready_o;
    do_alloc = accept && !merge_ok;
    do_merge = accept && merge_ok;

    head_d = drain    ? head_q + ptr_t'(1) : head_q;
    tail_d = do_alloc ? tail_q + ptr_t'(1) : tail_q;
    case ({do_alloc, drain})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    merge_data = data_q[young];
    for (int b = 0; b < 16; b++) begin
      if (st_byte_en_i[b]) merge_data[8*b +: 8] = st_data_i[8*b +: 8];
    end
  end

  // Walk the entries from oldest to youngest, so a later match overrides an
  // earlier one lane by lane. The entry draining this cycle is still
  // included, because the array read in this cycle returns pre-write data.
  always_comb begin
    fwd_be_d   = '0;
    fwd_data_d = '0;
    fwd_idx    = head_q;
    for (int i = 0; i < Entries; i++) begin
      fwd_idx = head_q + ptr_t'(i);
      if ((cnt_t'(i) < count_q) && (addr_q[fwd_idx] == ld_addr_i)) begin
        for (int b = 0; b < 16; b++) begin
          if (be_q[fwd_idx][b]) begin
            fwd_be_d[b]          = 1'b1;
            fwd_data_d[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
    if (!ld_valid_i) begin
      fwd_be_d   = '0;
      fwd_data_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      addr_q[tail_q] <= st_addr_i;
      data_q[tail_q] <= st_data_i;
      be_q[tail_q]   <= st_byte_en_i;
    end else if (do_merge) begin
      data_q[young] <= merge_data;
      be_q[young]   <= be_q[young] | st_byte_en_i;
    end
  end

  assign wr_en_o          = drain;
  assign wr_addr_o        = addr_q[head_q];
  assign wr_data_o        = data_q[head_q];
  assign wr_byte_en_o     = be_q[head_q];
  assign ld_fwd_byte_en_o = fwd_be_q;
  assign ld_fwd_data_o    = fwd_data_q;
  assign empty_o          = (count_q == '0);

endmodule

// File: tb/tb_l1d_store_drain_buf.sv
// Directed bench for l1d_store_drain_buf. It uses a 16-entry index space
// (LgDepth=4) and 4 buffer entries.

module tb_l1d_store_drain_buf;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         st_valid_i;
  logic         st_ready_o;
  logic [3:0]   st_addr_i;
  logic [127:0] st_data_i;
  logic [15:0]  st_byte_en_i;
  logic         arr_busy_i;
  logic         wr_en_o;
  logic [3:0]   wr_addr_o;
  logic [127:0] wr_data_o;
  logic [15:0]  wr_byte_en_o;
  logic         ld_valid_i;
  logic [3:0]   ld_addr_i;
  logic [15:0]  ld_fwd_byte_en_o;
  logic [127:0] ld_fwd_data_o;
  logic         empty_o;

  int n_checks = 0;
  int n_errors = 0;

  // Array writes seen, in order
  logic [3:0]   log_addr[$];
  logic [15:0]  log_be[$];
  logic [127:0] log_data[$];

  l1d_store_drain_buf #(
    .LgDepth  (4),
    .LgEntries(2)
  ) u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .st_valid_i      (st_valid_i),
    .st_ready_o      (st_ready_o),
    .st_addr_i       (st_addr_i),
    .st_data_i       (st_data_i),
    .st_byte_en_i    (st_byte_en_i),
    .arr_busy_i      (arr_busy_i),
    .wr_en_o         (wr_en_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .wr_byte_en_o    (wr_byte_en_o),
    .ld_valid_i      (ld_valid_i),
    .ld_addr_i       (ld_addr_i),
    .ld_fwd_byte_en_o(ld_fwd_byte_en_o),
    .ld_fwd_data_o   (ld_fwd_data_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (wr_en_o) begin
      log_addr.push_back(wr_addr_o);
      log_be.push_back(wr_byte_en_o);
      log_data.push_back(wr_data_o);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [3:0] a, input logic [15:0] be,
                          input logic [127:0] d);
    st_valid_i   = v;
    st_addr_i    = a;
    st_byte_en_i = be;
    st_data_i    = d;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_be.delete();
    log_data.delete();
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!empty_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, 128'(empty_o), 128'd1);
  endtask

  initial begin
    rst_ni     = 1'b0;
    arr_busy_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_addr_i  = '0;
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);

    // Reset state
    tick();
    tick();
    @(negedge clk_i);
    check("rst_empty", 128'(empty_o), 128'd1);
    check("rst_ready", 128'(st_ready_o), 128'd1);
    check("rst_wr_en", 128'(wr_en_o), 128'd0);
    check("rst_fwd_be", 128'(ld_fwd_byte_en_o), 128'h0);
    check("rst_fwd_data", ld_fwd_data_o, 128'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single store to index 5, written to the array in the next cycle
    drive_st(1'b1, 4'd5, 16'h000F, 128'hDEADBEEF);
    @(negedge clk_i);
    check("st1_ready", 128'(st_ready_o), 128'd1);
    check("st1_no_wr", 128'(wr_en_o), 128'd0);
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    @(negedge clk_i);
    check("st1_wr_en", 128'(wr_en_o), 128'd1);
    check("st1_wr_addr", 128'(wr_addr_o), 128'd5);
    check("st1_wr_be", 128'(wr_byte_en_o), 128'h000F);
    check("st1_wr_data", wr_data_o, 128'hDEADBEEF);
    tick();
    @(negedge clk_i);
    check("st1_empty", 128'(empty_o), 128'd1);
    check("st1_wr_idle", 128'(wr_en_o), 128'd0);
    tick();

    // Fill while the port is busy, merge into the youngest entry, then drain
    arr_busy_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive_st(1'b1, 4'(k), 16'h000F, 128'(32'h1111_1111 * k));
      @(negedge clk_i);
      check("fill_ready", 128'(st_ready_o), 128'd1);
      tick();
    end
    drive_st(1'b1, 4'd5, 16'h000F, 128'h5);
    @(negedge clk_i);
    check("full_ready", 128'(st_ready_o), 128'd0);
    tick();
    drive_st(1'b1, 4'd4, 16'hF000, {32'hCAFEBABE, {96{1'b1}}});
    @(negedge clk_i);
    check("full_merge_ready", 128'(st_ready_o), 128'd1);
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    clear_log();
    arr_busy_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("fill_nwr", 128'(log_addr.size()), 128'd4);
    if (log_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) check("fill_order", 128'(log_addr[k]), 128'(k + 1));
      check("fill_wr1_data", log_data[0], 128'h1111_1111);
      check("merge_be", 128'(log_be[3]), 128'hF00F);
      check("merge_data", log_data[3], {32'hCAFEBABE, 64'h0, 32'h4444_4444});
    end
    check("fill_empty", 128'(empty_o), 128'd1);

    // A store to the index of the only entry, which is draining, is not merged
    clear_log();
    drive_st(1'b1, 4'd7, 16'h0001, 128'h07);
    tick();
    drive_st(1'b1, 4'd7, 16'h0002, 128'h0700);
    @(negedge clk_i);
    check("nomerge_wr_en", 128'(wr_en_o), 128'd1);
    check("nomerge_ready", 128'(st_ready_o), 128'd1);
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    tick();
    tick();
    check("nomerge_nwr", 128'(log_addr.size()), 128'd2);
    if (log_addr.size() == 2) begin
      check("nomerge_addr0", 128'(log_addr[0]), 128'd7);
      check("nomerge_addr1", 128'(log_addr[1]), 128'd7);
      check("nomerge_be0", 128'(log_be[0]), 128'h0001);
      check("nomerge_be1", 128'(log_be[1]), 128'h0002);
    end

    // Forwarding: the youngest matching entry wins per lane
    arr_busy_i = 1'b1;
    drive_st(1'b1, 4'd3, 16'h00FF, {16{8'hAA}});
    tick();
    drive_st(1'b1, 4'd6, 16'hFFFF, {16{8'h66}});
    tick();
    drive_st(1'b1, 4'd3, 16'h0F0F, {16{8'hBB}});
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    ld_valid_i = 1'b1;
    ld_addr_i  = 4'd3;
    tick();
    ld_valid_i = 1'b0;
    @(negedge clk_i);
    check("fwd_be", 128'(ld_fwd_byte_en_o), 128'h0FFF);
    check("fwd_data", ld_fwd_data_o, {32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'hBBBBBBBB});
    tick();
    @(negedge clk_i);
    check("fwd_idle_be", 128'(ld_fwd_byte_en_o), 128'h0);
    check("fwd_idle_data", ld_fwd_data_o, 128'h0);
    arr_busy_i = 1'b0;
    wait_empty("fwd_drain_empty");

    // Forwarding covers an entry that drains in the same cycle as the load
    drive_st(1'b1, 4'd9, 16'h00F0, {16{8'h99}});
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    ld_valid_i = 1'b1;
    ld_addr_i  = 4'd9;
    @(negedge clk_i);
    check("drainfwd_wr_en", 128'(wr_en_o), 128'd1);
    check("drainfwd_wr_addr", 128'(wr_addr_o), 128'd9);
    tick();
    ld_valid_i = 1'b0;
    @(negedge clk_i);
    check("drainfwd_be", 128'(ld_fwd_byte_en_o), 128'h00F0);
    check("drainfwd_data", ld_fwd_data_o, {64'h0, 32'h99999999, 32'h0});
    check("drainfwd_empty", 128'(empty_o), 128'd1);
    // A store accepted in the same cycle as the load is not forwarded
    drive_st(1'b1, 4'd9, 16'h00F0, {16{8'h99}});
    ld_valid_i = 1'b1;
    tick();
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    ld_valid_i = 1'b0;
    @(negedge clk_i);
    check("samecyc_fwd_be", 128'(ld_fwd_byte_en_o), 128'h0);
    wait_empty("samecyc_empty");

    // Reset asserted mid-fill drops every entry
    arr_busy_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_st(1'b1, 4'(k), 16'hFFFF, 128'(k));
      tick();
    end
    drive_st(1'b0, 4'd0, 16'h0, 128'h0);
    check("prerst_not_empty", 128'(empty_o), 128'd0);
    arr_busy_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    check("midrst_empty", 128'(empty_o), 128'd1);
    check("midrst_wr_en", 128'(wr_en_o), 128'd0);
    check("midrst_ready", 128'(st_ready_o), 128'd1);
    clear_log();
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("midrst_no_wr", 128'(log_addr.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l1d_store_drain_buf.md
# l1d_store_drain_buf

Store drain buffer that sits directly upstream of the L1D data array's write port (the 2-read/1-write, 128-bit, byte-enabled data RAM). It accepts committed stores, keeps them in a small in-order queue, coalesces back-to-back stores to the same line index, and drains one entry per cycle into the array whenever the array write port is free. It also provides registered store-to-load forwarding, aligned to the array's one-cycle read latency, so loads never miss bytes that are still buffered.

## Interface
- LG_DEPTH, 1: array index width; must equal the data array's LG_DEPTH.
- LG_ENTRIES, 2: log2 of buffer entries (ENTRIES = 2**LG_ENTRIES).
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- st_valid  in  1  store offered.
- st_ready  out  1  store accepted when st_valid && st_ready.
- st_addr  in  LG_DEPTH  array index of the store.
- st_data  in  128  store data, byte-lane aligned.
- st_byte_en  in  16  byte lanes written.
- arr_busy  in  1  array write port taken (refill has priority); no drain this cycle.
- wr_en  out  1  array write strobe.
- wr_addr  out  LG_DEPTH  array write index.
- wr_data  out  128  array write data.
- wr_byte_en  out  16  array byte enables.
- ld_valid  in  1  load probing the array this cycle.
- ld_addr  in  LG_DEPTH  same index driven to the array read port.
- ld_fwd_byte_en  out  16  registered: lanes supplied by the buffer.
- ld_fwd_data  out  128  registered: forwarded data; lanes with ld_fwd_byte_en=0 are 0.
- empty  out  1  no valid entries.

## Operation
- Circular FIFO: head ptr, tail ptr, count (LG_ENTRIES+1 bits). Each entry holds addr, data, byte_en.
- Drain: drain = (count != 0) && !arr_busy. wr_en = drain; wr_addr/wr_data/wr_byte_en = head entry (combinational from registers). On drain, head advances (wraps at ENTRIES), count decrements.
- Merge: merge_ok = (count != 0) && youngest entry (tail-1) addr == st_addr && !(count == 1 && drain). On accepted merge, per lane with st_byte_en=1, youngest data byte is overwritten and its byte_en bit set; count unchanged.
- Allocate: an accepted store with !merge_ok writes the entry at tail; tail advances, count increments.
- st_ready = merge_ok || (count != ENTRIES). Full buffer does not count a same-cycle drain as space; arr_busy therefore reaches st_ready only through merge_ok.
- Simultaneous allocate and drain: count unchanged; both pointers advance.
- Forwarding: when ld_valid in cycle N, compare ld_addr against every entry valid at start of cycle N, including one draining in cycle N (array read in N returns pre-write data). Stores accepted in cycle N are excluded. Per lane, the youngest matching entry with that byte_en bit wins. Result registered; visible in cycle N+1. ld_valid=0 in N gives ld_fwd_byte_en=0 in N+1.
- empty = (count == 0).

## Timing
- Reset (reset=0, async): count=0, head=tail=0, wr_en=0, st_ready=1, empty=1, ld_fwd_byte_en=0, ld_fwd_data=0. Entry storage need not be cleared. Entries in flight at reset are dropped.
- Store-to-array latency: minimum 1 cycle (accepted in N, written to array in N+1 if arr_busy=0 in N+1).
- Forwarding latency: exactly 1 cycle, matching array read data.
- Only one entry is drained per cycle. Order of array writes equals allocation order.
- arr_busy held high: no drain; buffer fills to ENTRIES, then accepts only merges to the youngest entry.

## Test plan
- Reset, single store addr=5, be=16'h000F, data=...0xDEADBEEF, arr_busy=0 -> wr_en=1 next cycle with addr=5, be=16'h000F; empty=1 after.
- arr_busy=1, stores to addr 1,2,3,4 -> st_ready=0 after the 4th; store to addr 4 be=16'hF000 still accepted (merge); release arr_busy -> four writes in order 1,2,3,4; addr 4 be = union of both.
- count=1 at addr 7 draining this cycle, new store addr 7 -> allocated as a new entry, not merged; two writes to addr 7.
- Entries addr 3 be=16'h00FF data A, then addr 3 be=16'h0F0F data B (separate entries); ld addr 3 -> next cycle ld_fwd_byte_en=16'h0FFF, lanes 0-3 and 8-11 from B, lanes 4-7 from A.
- Load addr 9 in the same cycle the only addr-9 entry drains -> fwd hit next cycle; load addr 9 in the same cycle a store to 9 is accepted into an empty buffer -> ld_fwd_byte_en=0.
- Assert reset mid-fill with 3 entries -> immediately empty=1, wr_en=0, st_ready=1; no writes after release.
